// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
//   Accepts one load/store at a time over a valid/ready handshake, waits
//   WAIT_STATES cycles, performs the access on the edge entering RESP, then
//   pulses o_resp_valid for one cycle.
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset, synchronous release
//   i_req_valid   request present, held stable until accepted
//   o_req_ready   responder is in IDLE and will accept a request
//   i_req_write   1 = store, 0 = load
//   i_req_addr    byte address, bits [1:0] ignored
//   i_req_wdata   lane-aligned store data
//   i_req_be      store byte-lane enables
//   o_resp_valid  one-cycle completion pulse
//   o_resp_rdata  load data, held until the next response
//   o_resp_err    word index out of range
//   o_busy        high in WAIT and RESP
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;
    state_t      r_state, w_next_state;
    logic [3:0]  r_wait_cnt, w_next_wait_cnt;
    logic        r_write;
    logic [29:0] r_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        w_accept;
    logic        w_access;
    logic        w_idle;
    logic        w_acc_write;
    logic [29:0] w_acc_idx;
    logic [31:0] w_acc_wdata;
    logic [3:0]  w_acc_be;
    logic        w_in_range;
    logic [AW-1:0] w_mem_idx;
    logic        w_unused;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & i_req_valid;
    // With no wait states the access happens on the acceptance edge itself.
    assign w_access = (WAIT_STATES == 0) ? w_accept
                                         : (r_state == S_WAIT) & (r_wait_cnt == 4'd0);

    // On the acceptance edge the request is still on the inputs; later it is in the latches.
    assign w_acc_write = w_idle ? i_req_write       : r_write;
    assign w_acc_idx   = w_idle ? i_req_addr[31:2]  : r_idx;
    assign w_acc_wdata = w_idle ? i_req_wdata       : r_wdata;
    assign w_acc_be    = w_idle ? i_req_be          : r_be;
    assign w_in_range  = {2'b00, w_acc_idx} < 32'(DEPTH_WORDS);
    assign w_mem_idx   = w_acc_idx[AW-1:0];
    assign w_unused    = ^i_req_addr[1:0];

    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_next_state    = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    w_next_wait_cnt = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) w_next_state = S_RESP;
                else w_next_wait_cnt = r_wait_cnt - 4'd1;
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_write      <= 1'b0;
            r_idx        <= 30'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            if (w_accept) begin
                r_write <= i_req_write;
                r_idx   <= i_req_addr[31:2];
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
            end
            if (w_access) begin
                r_resp_err   <= ~w_in_range;
                r_resp_rdata <= (w_in_range & ~w_acc_write) ? r_mem[w_mem_idx] : 32'd0;
            end
        end
    end

    // Storage has no reset; a store is blocked while reset is asserted so an
    // aborted transaction never commits.
    always_ff @(posedge i_clk) begin
        if (i_rst_n & w_access & w_acc_write & w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
        end
    end

    assign o_req_ready  = w_idle;
    assign o_resp_valid = (r_state == S_RESP);
    assign o_busy       = ~w_idle;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic [3:0]  i_req_be = 4'd0;
    logic        o_req_ready;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] m_mem [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_be(i_req_be), .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
        .o_resp_err(o_resp_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                         input logic [3:0] be, output logic [31:0] rd, output logic er);
        int idx;
        idx = int'(a >> 2);
        if (idx >= DEPTH) begin
            rd = 32'd0;
            er = 1'b1;
        end else begin
            er = 1'b0;
            rd = w ? 32'd0 : m_mem[idx];
            if (w) for (int b = 0; b < 4; b++) if (be[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        i_req_valid = 1'b1;
        i_req_write = w;
        i_req_addr  = a;
        i_req_wdata = wd;
        i_req_be    = be;
    endtask

    // Presents a request from a negedge, returns edges from acceptance to the
    // response (-1 if it never completes); ends on the negedge of the response cycle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
        logic acc;
        int n;
        drive(w, a, wd, be);
        acc = 1'b0;
        n = 0;
        lat = -1;
        rd = 32'hx;
        er = 1'bx;
        while (!acc && n < 50) begin
            acc = o_req_ready;
            @(posedge i_clk);
            @(negedge i_clk);
            n++;
        end
        i_req_valid = 1'b0;
        if (acc) begin
            n = 0;
            while (!o_resp_valid && n < 50) begin
                @(posedge i_clk);
                @(negedge i_clk);
                n++;
            end
            if (o_resp_valid) begin
                lat = n;
                rd = o_resp_rdata;
                er = o_resp_err;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks += 5;
        if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_req_ready); end
        if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_resp_valid); end
        if (o_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", o_resp_rdata); end
        if (o_resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", o_resp_err); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            n_checks += 3;
            if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready c=%0d got %b want 1", c, o_req_ready); end
            if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid c=%0d got %b want 0", c, o_resp_valid); end
            if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy c=%0d got %b want 0", c, o_busy); end
        end
    endtask

    task automatic test_store_load();
        int lat;
        logic [31:0] rd, erd;
        logic er, eer;
        model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
        n_checks += 3;
        if (lat !== WS) begin n_fail++; $display("FAIL store_latency got %0d want %0d", lat, WS); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got %b want 0", er); end
        if (rd !== 32'd0) begin n_fail++; $display("FAIL store_rdata got %h want 0", rd); end
        @(negedge i_clk);
        n_checks += 2;
        if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL store_pulse_width got %b want 0", o_resp_valid); end
        if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_back_idle got %b want 1", o_req_ready); end
        model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        n_checks += 4;
        if (lat !== WS) begin n_fail++; $display("FAIL load_latency got %0d want %0d", lat, WS); end
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got %h want DEADBEEF", rd); end
        if (rd !== erd) begin n_fail++; $display("FAIL load_rdata_model got %h want %h", rd, erd); end
        if (er !== eer) begin n_fail++; $display("FAIL load_err got %b want %b", er, eer); end
        @(negedge i_clk);
        n_checks++;
        if (o_resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold got %h want DEADBEEF", o_resp_rdata); end
    endtask

    task automatic test_partial_store();
        int lat;
        logic [31:0] rd, erd;
        logic er, eer;
        model_access(1'b1, 32'h10, 32'h0000AA00, 4'b0010, erd, eer);
        issue(1'b1, 32'h10, 32'h0000AA00, 4'b0010, lat, rd, er);
        model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        n_checks += 2;
        if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL partial_rdata got %h want DEADAAEF", rd); end
        if (rd !== erd) begin n_fail++; $display("FAIL partial_model got %h want %h", rd, erd); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [31:0] rd, erd;
        logic er, eer;
        issue(1'b0, 32'h400, 32'h0, 4'h0, lat, rd, er);
        n_checks += 3;
        if (er !== 1'b1) begin n_fail++; $display("FAIL oob_load_err got %b want 1", er); end
        if (rd !== 32'd0) begin n_fail++; $display("FAIL oob_load_rdata got %h want 0", rd); end
        if (lat !== WS) begin n_fail++; $display("FAIL oob_latency got %0d want %0d", lat, WS); end
        model_access(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, erd, eer);
        issue(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, lat, rd, er);
        n_checks++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL oob_store_err got %b want 1", er); end
        model_access(1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        issue(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
        n_checks += 2;
        if (rd !== erd) begin n_fail++; $display("FAIL oob_mem0_intact got %h want %h", rd, erd); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL mem0_err got %b want 0", er); end
    endtask

    task automatic test_back_to_back();
        logic        w [4];
        logic [31:0] a [4];
        logic [31:0] wd [4];
        logic [3:0]  be [4];
        logic [31:0] exp_rd [$];
        int          resp_cyc [$];
        logic [31:0] got_rd [$];
        logic [31:0] r;
        logic        e;
        logic        acc;
        int          k;
        w  = '{1'b1, 1'b0, 1'b1, 1'b0};
        a  = '{32'h40, 32'h40, 32'h40, 32'h40};
        wd = '{$urandom, 32'h0, $urandom, 32'h0};
        be = '{4'hF, 4'h0, 4'b1001, 4'h0};
        @(negedge i_clk);
        k = 0;
        drive(w[0], a[0], wd[0], be[0]);
        for (int cyc = 0; cyc < 24; cyc++) begin
            acc = o_req_ready & i_req_valid;
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_resp_valid) begin
                resp_cyc.push_back(cyc);
                got_rd.push_back(o_resp_rdata);
            end
            if (acc) begin
                model_access(w[k], a[k], wd[k], be[k], r, e);
                exp_rd.push_back(r);
                k++;
                if (k < 4) drive(w[k], a[k], wd[k], be[k]);
                else i_req_valid = 1'b0;
            end
        end
        n_checks++;
        if (resp_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", resp_cyc.size()); end
        for (int i = 0; i < 4 && i < resp_cyc.size() && i < exp_rd.size(); i++) begin
            n_checks += 2;
            if (resp_cyc[i] != WS + i * (WS + 2)) begin
                n_fail++; $display("FAIL b2b_timing i=%0d got %0d want %0d", i, resp_cyc[i], WS + i * (WS + 2));
            end
            if (got_rd[i] !== exp_rd[i]) begin
                n_fail++; $display("FAIL b2b_rdata i=%0d got %h want %h", i, got_rd[i], exp_rd[i]);
            end
        end
        if (got_rd.size() > 1) begin
            n_checks++;
            if (got_rd[1] !== wd[0]) begin n_fail++; $display("FAIL b2b_store_then_load got %h want %h", got_rd[1], wd[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] rd, erd;
        logic er, eer;
        model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        drive(1'b1, 32'h20, 32'h12345678, 4'hF);
        while (!o_req_ready) @(negedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        n_checks += 2;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", o_busy); end
        if (o_resp_rdata !== erd) begin n_fail++; $display("FAIL mid_rdata_before got %h want %h", o_resp_rdata, erd); end
        i_rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", o_req_ready); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", o_busy); end
        if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", o_resp_valid); end
        if (o_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rdata got %h want 0", o_resp_rdata); end
        @(negedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        issue(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        n_checks += 2;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL mid_store_dropped got %h want 0", rd); end
        if (rd !== erd) begin n_fail++; $display("FAIL mid_model got %h want %h", rd, erd); end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] rd, erd, a;
        logic er, eer, w;
        logic [31:0] wd;
        logic [3:0] be;
        for (int t = 0; t < 40; t++) begin
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom);
            a  = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(DEPTH, DEPTH + 8)) << 2;
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h8000_0000;
            model_access(w, a, wd, be, erd, eer);
            issue(w, a, wd, be, lat, rd, er);
            n_checks += 3;
            if (lat !== WS) begin n_fail++; $display("FAIL rand_latency t=%0d got %0d want %0d", t, lat, WS); end
            if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata t=%0d addr=%h got %h want %h", t, a, rd, erd); end
            if (er !== eer) begin n_fail++; $display("FAIL rand_err t=%0d addr=%h got %b want %b", t, a, er, eer); end
            if ($urandom_range(0, 2) == 0) @(negedge i_clk);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = (i == 8) ? 32'd0 : $urandom;
            dut.r_mem[i] = m_mem[i];
        end
        test_reset();
        test_store_load();
        test_partial_store();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the processor's MEM stage: accepts one load/store request at a time over a valid/ready handshake, inserts a fixed number of wait states, commits stores with byte-lane enables, and returns load data with a one-cycle response strobe. It sits where the single-cycle data memory sits today, so the pipeline can run against realistic multi-cycle memory. The controller stalls the pipeline on `req_valid & ~resp_valid`.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; word index is `req_addr[31:2]`.
- `WAIT_STATES`, 2: extra cycles between acceptance and response; legal range 0–15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. `rst`=0 forces reset immediately; release is synchronous to `clk`.
- `req_valid`  in  1  request present; the initiator holds all `req_*` stable until accepted.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; bits [1:0] are ignored, so access is word-aligned.
- `req_wdata`  in  32  store data, already lane-aligned.
- `req_be`  in  4  store byte-lane enables; bit i enables `wdata[8i+7:8i]`; ignored for loads.
- `resp_valid`  out  1  one-cycle pulse: the request completed.
- `resp_rdata`  out  32  load data; meaningful only with `resp_valid`; holds its value until the next response.
- `resp_err`  out  1  valid with `resp_valid`: word index ≥ `DEPTH_WORDS`.
- `busy`  out  1  high in WAIT and RESP states.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE
  - `req_ready`=1.
  - On `req_valid & req_ready`, the responder latches `write`, `addr`, `wdata` and `be`.
  - With `WAIT_STATES`=0 the next state is RESP; otherwise it is WAIT, with `wait_cnt` loaded to `WAIT_STATES`-1.
- WAIT
  - `req_ready`=0.
  - `wait_cnt` decrements each cycle.
  - On the cycle `wait_cnt`==0, the responder performs the access at the clock edge and goes to RESP.
- Access edge. This is the edge entering RESP; for `WAIT_STATES`=0 it is the acceptance edge itself.
  - Load: `resp_rdata` ← `mem[idx]`.
  - Store: `mem[idx]` lanes with `be`=1 ← `wdata`; the other lanes are unchanged; `resp_rdata` ← 0.
  - Out-of-range index: memory is unmodified, `resp_rdata` ← 0, `resp_err` ← 1. Otherwise `resp_err` ← 0.
- RESP
  - `resp_valid`=1 for exactly one cycle and `req_ready`=0.
  - Unconditional return to IDLE; there is no response backpressure.
- Requests presented while not in IDLE are not accepted. They stay pending and are accepted on the first IDLE cycle.
- Back-to-back requests: a store followed by a load to the same word returns the stored data (the store is committed before the load is accepted).
- Memory contents are not cleared by reset and are undefined at power-up. The bench preloads them via hierarchical access.

## Timing
- Reset values:
  - `req_ready`=1
  - `resp_valid`=0
  - `resp_rdata`=0
  - `resp_err`=0
  - `busy`=0
  - state IDLE, `wait_cnt`=0
- Latency: a request is accepted at edge E0 and `resp_valid` is high in the cycle after edge E0+`WAIT_STATES`. That is `WAIT_STATES`+1 cycles from the request cycle to the response cycle.
- Throughput: one request per `WAIT_STATES`+2 cycles, because the IDLE cycle is required between transactions.
- `req_ready` is a registered state decode; it does not depend combinationally on `req_valid`.
- `resp_rdata`, `resp_err` and `resp_valid` are registered outputs.
- Reset asserted mid-transaction:
  - Before the access edge, the store is not committed.
  - Outputs take their reset values asynchronously.
  - The pending request must be re-presented after reset.

## Test plan
- Reset, then idle with `WAIT_STATES`=2: `req_ready`=1, `resp_valid`=0 and `busy`=0 for 10 cycles.
- Store `addr`=0x10, `wdata`=0xDEADBEEF, `be`=4'hF, accepted at edge E0: `resp_valid` is high only in the cycle after E0+2, with `resp_err`=0. A following load of 0x10 returns 0xDEADBEEF three cycles after its own acceptance.
- Partial store to `addr`=0x10, `wdata`=0x0000AA00, `be`=4'b0010, then load 0x10: returns 0xDEADAAEF.
- Load `addr`=0x400 (index 256) with `DEPTH_WORDS`=256: `resp_err`=1 and `resp_rdata`=0. A store to 0x400 leaves `mem[0]` unchanged.
- `req_valid` held continuously with a new request queued during WAIT: it is not accepted until IDLE. Four requests complete in 16 cycles, with responses 4 cycles apart.
- `rst` pulled low during WAIT of a store of 0x12345678 to 0x20 (previously 0): outputs reset immediately. A subsequent load of 0x20 returns 0.
